// File: rtl/alu_pin_driver.sv
// Initiator for the 8-pin ALU: packs commands onto the pins, waits out ALU latency, returns checked responses.
// Optional macro ALU_DIV0_GUARD_EN short-circuits divide-by-zero commands without touching the pins.
module alu_pin_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_a,
    input  logic [2:0]       cmd_b,
    output logic [7:0]       alu_in,
    input  logic [7:0]       alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_result,
    output logic [1:0]       rsp_op,
    output logic             rsp_err,
    output logic             rsp_div0,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    // Out-of-range settle values are clamped into 1..15 so the counter always terminates.
    localparam int SC_INT = (SETTLE_CYCLES < 1)  ? 1  :
                            (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] SC = SC_INT[3:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] op_q;
    logic [2:0] b_q;
    logic [3:0] cnt;

`ifdef ALU_DIV0_GUARD_EN
    logic div0_cmd;
    assign div0_cmd = (cmd_op == 2'b11) && (cmd_b == 3'd0);
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_in     <= 8'h00;
            op_q       <= 2'b00;
            b_q        <= 3'd0;
            cnt        <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_result <= 6'd0;
            rsp_op     <= 2'b00;
            rsp_err    <= 1'b0;
            rsp_div0   <= 1'b0;
            txn_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        b_q  <= cmd_b;
`ifdef ALU_DIV0_GUARD_EN
                        // Guarded divide-by-zero never reaches the pins, so the ALU echo stays untouched.
                        if (div0_cmd) begin
                            rsp_result <= 6'd0;
                            rsp_op     <= 2'b11;
                            rsp_err    <= 1'b0;
                            rsp_div0   <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            alu_in <= {cmd_op, cmd_b, cmd_a};
                            state  <= DRIVE;
                        end
`else
                        alu_in <= {cmd_op, cmd_b, cmd_a};
                        state  <= DRIVE;
`endif
                    end
                end
                DRIVE: begin
                    cnt   <= SC;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt <= 4'd1) begin
                        rsp_result <= alu_out[5:0];
                        rsp_op     <= op_q;
                        rsp_err    <= (alu_out[7:6] != op_q);
                        rsp_div0   <= (op_q == 2'b11) && (b_q == 3'd0);
                        rsp_valid  <= 1'b1;
                        cnt        <= 4'd0;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pin_driver.sv
// Directed bench for alu_pin_driver with a registered ALU model and a response scoreboard.
module tb_alu_pin_driver;

    localparam int SC = 3;

    logic        CLK = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_a;
    logic [2:0]  cmd_b;
    logic [7:0]  alu_in;
    logic [7:0]  alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_result;
    logic [1:0]  rsp_op;
    logic        rsp_err;
    logic        rsp_div0;
    logic        busy;
    logic [15:0] txn_count;

    alu_pin_driver #(.SETTLE_CYCLES(SC), .CNT_W(16)) dut (
        .CLK(CLK), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in(alu_in), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op),
        .rsp_err(rsp_err), .rsp_div0(rsp_div0),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu_calc(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        logic [7:0] ea, eb;
        ea = {5'd0, a};
        eb = {5'd0, b};
        case (op)
            2'b00:   alu_calc = ea + eb;
            2'b01:   alu_calc = ea - eb;
            2'b10:   alu_calc = ea * eb;
            default: alu_calc = (b == 3'd0) ? 8'hFF : ea / eb;
        endcase
    endfunction

    // ALU model: result registered on each edge, echo combinational from the pins.
    logic [7:0] alu_res_q = 8'h00;
    logic       force_echo = 1'b0;
    always @(posedge CLK) alu_res_q <= alu_calc(alu_in[7:6], alu_in[2:0], alu_in[5:3]);
    assign alu_out = {(force_echo ? 2'b00 : alu_in[7:6]), alu_res_q[5:0]};

    typedef struct {
        logic [5:0] res;
        logic [1:0] op;
        logic       err;
        logic       div0;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [7:0]  last_drv = 8'h00;
    logic [15:0] exp_txn  = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic fe, input int hold);
        exp_t       e, got;
        logic       guard;
        logic [7:0] full;
        logic [7:0] exp_in;
        int         n;
        guard = 1'b0;
`ifdef ALU_DIV0_GUARD_EN
        guard = (op == 2'b11) && (b == 3'd0);
`endif
        full   = alu_calc(op, a, b);
        e.res  = guard ? 6'd0 : full[5:0];
        e.op   = op;
        e.err  = fe && !guard && (op != 2'b00);
        e.div0 = (op == 2'b11) && (b == 3'd0);
        sb.push_back(e);
        exp_in = guard ? last_drv : {op, b, a};

        force_echo = fe;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_a      = a;
        cmd_b      = b;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        chk("alu_in_pack", alu_in, exp_in);
        last_drv = exp_in;
        chk("busy_after_accept", busy, 1'b1);

        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("latency", n, guard ? 0 : 1 + SC);
        got = sb.pop_front();
        chk("rsp_result", rsp_result, got.res);
        chk("rsp_op", rsp_op, got.op);
        chk("rsp_err", rsp_err, got.err);
        chk("rsp_div0", rsp_div0, got.div0);

        // Backpressure: new commands must be ignored and fields must hold.
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_a     = 3'd1;
            cmd_b     = 3'd2;
            @(posedge CLK); #1;
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_result", rsp_result, got.res);
            chk("hold_txn_count", txn_count, exp_txn);
            chk("hold_alu_in", alu_in, exp_in);
        end
        cmd_valid = 1'b0;

        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready  = 1'b0;
        force_echo = 1'b0;
        exp_txn++;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("txn_count", txn_count, exp_txn);
        chk("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 3'd0;
        cmd_b     = 3'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_alu_in", alu_in, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 6'd0);
        chk("rst_txn_count", txn_count, 16'd0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(posedge CLK); #1;

        run_cmd(2'b00, 3'd3, 3'd5, 1'b0, 0);   // add 3+5 = 8
        run_cmd(2'b01, 3'd2, 3'd5, 1'b0, 1);   // sub wraps to 61
        run_cmd(2'b10, 3'd7, 3'd7, 1'b0, 0);   // mul 49
        run_cmd(2'b11, 3'd6, 3'd4, 1'b0, 5);   // div 1 under backpressure
        run_cmd(2'b10, 3'd3, 3'd2, 1'b1, 0);   // echo fault
        run_cmd(2'b11, 3'd5, 3'd0, 1'b0, 0);   // divide by zero
        run_cmd(2'b00, 3'd7, 3'd7, 1'b0, 2);   // add 14

        // Reset in the middle of SETTLE abandons the transaction.
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_a     = 3'd2;
        cmd_b     = 3'd2;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_alu_in", alu_in, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_txn", txn_count, 16'd0);
        last_drv = 8'h00;
        exp_txn  = 16'd0;
        @(posedge CLK); #1;
        rst = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_no_rsp", rsp_valid, 1'b0);
        run_cmd(2'b00, 3'd1, 3'd1, 1'b0, 0);   // add 1+1 = 2

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
